// File: rtl/wb_dsp_equation_scheduler_if.sv
// Launch/track link between the equation scheduler and the equation state machine.
// Handshake: sm_start is a single-cycle launch strobe qualified by sm_select and
// sm_base_address (both held until the next launch); the state machine answers by
// raising sm_active while it runs and dropping it when finished, with sm_error
// flagging a bus error at any point during the run.
interface wb_dsp_equation_scheduler_if #(
  parameter int aw = 32
);
  logic          sm_start;
  logic [aw-1:0] sm_base_address;
  logic [1:0]    sm_select;
  logic          sm_active;
  logic          sm_error;

  modport master (
    output sm_start, sm_base_address, sm_select,
    input  sm_active, sm_error
  );

  modport slave (
    input  sm_start, sm_base_address, sm_select,
    output sm_active, sm_error
  );
endinterface

// File: rtl/wb_dsp_equation_scheduler.sv
// Round-robin scheduler for equations 0-3: queues start requests, launches the
// equation state machine one grant at a time and reports done/error per equation.
module wb_dsp_equation_scheduler #(
  parameter int dw      = 32,
  parameter int aw      = 32,
  parameter int TIMEOUT = 1024,
  parameter int TW      = 16
) (
  input  logic                    wb_clk,
  input  logic                    wb_rst,
  input  logic [3:0]              request,
  input  logic                    stop,
  input  logic [dw-1:0]           equation0_address_reg,
  input  logic [dw-1:0]           equation1_address_reg,
  input  logic [dw-1:0]           equation2_address_reg,
  input  logic [dw-1:0]           equation3_address_reg,
  wb_dsp_equation_scheduler_if.master sm,
  output logic [3:0]              pending,
  output logic                    busy,
  output logic [3:0]              done,
  output logic [3:0]              error,
  output logic                    timeout,
  output logic [2:0]              state_dbg
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    LAUNCH      = 3'd1,
    WAIT_ACTIVE = 3'd2,
    WAIT_DONE   = 3'd3,
    COMPLETE    = 3'd4
  } state_t;

  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);
  localparam bit            TO_EN    = (TIMEOUT != 0);

  state_t        state;
  logic [1:0]    last_grant;
  logic [1:0]    grant;
  logic [1:0]    idx;
  logic          grant_valid;
  logic [dw-1:0] addr_sel;
  logic [TW-1:0] cnt;
  logic          err_flag;
  logic [3:0]    sel_onehot;
  logic [3:0]    clr_mask;
  logic          at_limit;
  logic          to_hit;

  // Walk from farthest to nearest so the first set bit after last_grant wins.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int k = 4; k >= 1; k--) begin
      idx = last_grant + 2'(k);
      if (pending[idx]) begin
        grant       = idx;
        grant_valid = 1'b1;
      end
    end
  end

  always_comb begin
    case (grant)
      2'd0:    addr_sel = equation0_address_reg;
      2'd1:    addr_sel = equation1_address_reg;
      2'd2:    addr_sel = equation2_address_reg;
      default: addr_sel = equation3_address_reg;
    endcase
  end

  assign sel_onehot = 4'b0001 << sm.sm_select;
  assign clr_mask   = (state == COMPLETE) ? sel_onehot : 4'b0000;
  assign at_limit   = TO_EN && (cnt == CNT_LAST);
  // A rising sm_active in WAIT_ACTIVE or a falling one in WAIT_DONE beats the timeout.
  assign to_hit     = at_limit &&
                      (((state == WAIT_ACTIVE) && !sm.sm_active) ||
                       ((state == WAIT_DONE) && sm.sm_active));
  assign state_dbg  = state;

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state              <= IDLE;
      pending            <= 4'b0000;
      busy               <= 1'b0;
      done               <= 4'b0000;
      error              <= 4'b0000;
      timeout            <= 1'b0;
      sm.sm_start        <= 1'b0;
      sm.sm_select       <= 2'd0;
      sm.sm_base_address <= '0;
      last_grant         <= 2'd3;
      cnt                <= '0;
      err_flag           <= 1'b0;
    end else begin
      sm.sm_start <= 1'b0;
      done        <= 4'b0000;
      error       <= 4'b0000;
      // Set beats the COMPLETE clear so a request landing then re-queues.
      pending     <= stop ? 4'b0000 : ((pending & ~clr_mask) | request);
      if (stop)        timeout <= 1'b0;
      else if (to_hit) timeout <= 1'b1;

      case (state)
        IDLE: begin
          if (grant_valid && !stop) begin
            sm.sm_select       <= grant;
            sm.sm_base_address <= aw'(addr_sel);
            sm.sm_start        <= 1'b1;
            busy               <= 1'b1;
            state              <= LAUNCH;
          end
        end
        LAUNCH: begin
          cnt      <= '0;
          err_flag <= 1'b0;
          state    <= WAIT_ACTIVE;
        end
        WAIT_ACTIVE: begin
          cnt <= cnt + 1'b1;
          if (sm.sm_active) begin
            state <= WAIT_DONE;
          end else if (to_hit) begin
            error <= sel_onehot;
            state <= COMPLETE;
          end
        end
        WAIT_DONE: begin
          cnt <= cnt + 1'b1;
          if (!sm.sm_active) begin
            if (err_flag || sm.sm_error) error <= sel_onehot;
            else                         done  <= sel_onehot;
            state <= COMPLETE;
          end else if (to_hit) begin
            error <= sel_onehot;
            state <= COMPLETE;
          end else if (sm.sm_error) begin
            err_flag <= 1'b1;
          end
        end
        COMPLETE: begin
          last_grant <= sm.sm_select;
          err_flag   <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_dsp_equation_scheduler.sv
// Directed bench for wb_dsp_equation_scheduler with a small equation state machine responder.
module tb_wb_dsp_equation_scheduler;

  localparam int TO = 16;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic [3:0]  request;
  logic        stop;
  logic [31:0] eq0_addr, eq1_addr, eq2_addr, eq3_addr;
  logic [3:0]  pending, done, error;
  logic        busy, timeout;
  logic [2:0]  state_dbg;

  wb_dsp_equation_scheduler_if #(.aw(32)) sm ();

  wb_dsp_equation_scheduler #(.dw(32), .aw(32), .TIMEOUT(TO), .TW(16)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .request(request), .stop(stop),
    .equation0_address_reg(eq0_addr), .equation1_address_reg(eq1_addr),
    .equation2_address_reg(eq2_addr), .equation3_address_reg(eq3_addr),
    .sm(sm), .pending(pending), .busy(busy), .done(done), .error(error),
    .timeout(timeout), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 wb_clk = ~wb_clk;

  int total = 0;
  int bad   = 0;

  // observation log and expected queue
  int         start_cnt = 0;
  logic [1:0] grant_q[$];
  logic [3:0] done_q[$];
  logic [3:0] err_q[$];
  logic [1:0] exp_q[$];
  bit         overlap_seen = 1'b0;

  bit resp_en  = 1'b1;
  bit resp_err = 1'b0;
  int resp_len = 3;

  initial begin
    sm.sm_active = 1'b0;
    sm.sm_error  = 1'b0;
    forever begin
      @(negedge wb_clk);
      if (sm.sm_start && resp_en) begin
        sm.sm_active = 1'b1;
        sm.sm_error  = resp_err;
        repeat (resp_len) @(negedge wb_clk);
        sm.sm_active = 1'b0;
        sm.sm_error  = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge wb_clk);
      if (sm.sm_start) begin
        start_cnt++;
        grant_q.push_back(sm.sm_select);
      end
      if (done != 0) done_q.push_back(done);
      if (error != 0) err_q.push_back(error);
      if ((done != 0 && error != 0) || $countones(done) > 1 || $countones(error) > 1)
        overlap_seen = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic do_reset();
    wb_rst = 1'b1; request = 4'b0; stop = 1'b0;
    repeat (3) @(negedge wb_clk);
    wb_rst = 1'b0;
  endtask

  task automatic clear_logs();
    start_cnt = 0;
    grant_q.delete(); done_q.delete(); err_q.delete();
  endtask

  task automatic pulse_request(input logic [3:0] m);
    @(negedge wb_clk); request = m;
    @(negedge wb_clk); request = 4'b0;
  endtask

  task automatic wait_quiet(input int budget, output bit ok);
    int n = 0;
    @(negedge wb_clk);
    while ((busy || pending != 0) && n < budget) begin
      @(negedge wb_clk); n++;
    end
    ok = !(busy || pending != 0);
    #1;
  endtask

  task automatic wait_start(input int budget, output bit ok);
    int n = 0;
    do begin @(negedge wb_clk); n++; end while (!sm.sm_start && n < budget);
    ok = sm.sm_start;
  endtask

  task automatic wait_pulse(input int budget, output int n);
    n = 0;
    do begin @(negedge wb_clk); n++; end while (done == 0 && error == 0 && n < budget);
  endtask

  // tests
  task automatic test_reset();
    do_reset();
    total++;
    if ({sm.sm_start, sm.sm_select, busy, done, error, timeout, pending} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got start=%b sel=%0d busy=%b done=%b err=%b to=%b pend=%b want all 0",
               sm.sm_start, sm.sm_select, busy, done, error, timeout, pending);
    end
    total++;
    if (sm.sm_base_address !== 32'h0) begin
      bad++; $display("FAIL reset_base: got %h want 0", sm.sm_base_address);
    end
    total++;
    if (state_dbg !== 3'd0) begin
      bad++; $display("FAIL reset_state: got %0d want 0", state_dbg);
    end
  endtask

  task automatic test_single();
    int n;
    bit ok;
    clear_logs();
    resp_len = 5;
    @(negedge wb_clk); request = 4'b0100;
    @(negedge wb_clk); request = 4'b0000;
    total++;
    if (pending !== 4'b0100) begin
      bad++; $display("FAIL single_pending: got %b want 0100", pending);
    end
    @(negedge wb_clk);
    total++;
    if (sm.sm_start !== 1'b1 || sm.sm_select !== 2'd2 || busy !== 1'b1) begin
      bad++; $display("FAIL single_launch: got start=%b sel=%0d busy=%b want 1 2 1", sm.sm_start, sm.sm_select, busy);
    end
    total++;
    if (sm.sm_base_address !== eq2_addr) begin
      bad++; $display("FAIL single_base: got %h want %h", sm.sm_base_address, eq2_addr);
    end
    wait_pulse(30, n);
    total++;
    if (n != 6 || done !== 4'b0100 || error !== 4'b0000) begin
      bad++; $display("FAIL single_done: got cycles=%0d done=%b err=%b want 6 0100 0000", n, done, error);
    end
    @(negedge wb_clk);
    total++;
    if (pending !== 4'b0000 || done !== 4'b0000) begin
      bad++; $display("FAIL single_clear: got pend=%b done=%b want 0000 0000", pending, done);
    end
    wait_quiet(50, ok);
    total++;
    if (!ok || start_cnt != 1) begin
      bad++; $display("FAIL single_starts: got quiet=%b starts=%0d want 1 1", ok, start_cnt);
    end
  endtask

  task automatic test_fairness();
    bit ok;
    logic [1:0] got;
    do_reset();
    clear_logs();
    resp_len = 3;
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3};
    pulse_request(4'b1111);
    wait_quiet(200, ok);
    total++;
    if (!ok || grant_q.size() != 4) begin
      bad++; $display("FAIL fair_count: got quiet=%b grants=%0d want 1 4", ok, grant_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < grant_q.size()) ? grant_q[i] : 2'bxx;
      total++;
      if (got !== exp_q[i]) begin
        bad++; $display("FAIL fair_order[%0d]: got %0d want %0d", i, got, exp_q[i]);
      end
    end
    total++;
    if (done_q.size() != 4 || err_q.size() != 0) begin
      bad++; $display("FAIL fair_done: got done=%0d err=%0d want 4 0", done_q.size(), err_q.size());
    end
    clear_logs();
    exp_q = '{2'd0, 2'd1};
    pulse_request(4'b0011);
    wait_quiet(200, ok);
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < grant_q.size()) ? grant_q[i] : 2'bxx;
      total++;
      if (got !== exp_q[i]) begin
        bad++; $display("FAIL fair_wrap[%0d]: got %0d want %0d", i, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_requeue();
    int n;
    bit ok;
    do_reset();
    clear_logs();
    resp_len = 3;
    pulse_request(4'b0010);
    wait_pulse(30, n);
    request = 4'b0010;
    @(negedge wb_clk); request = 4'b0000;
    total++;
    if (pending !== 4'b0010 || state_dbg !== 3'd0) begin
      bad++; $display("FAIL requeue_pending: got pend=%b state=%0d want 0010 0", pending, state_dbg);
    end
    @(negedge wb_clk);
    total++;
    if (sm.sm_start !== 1'b1 || sm.sm_select !== 2'd1) begin
      bad++; $display("FAIL requeue_launch: got start=%b sel=%0d want 1 1", sm.sm_start, sm.sm_select);
    end
    wait_quiet(100, ok);
    total++;
    if (!ok || start_cnt != 2 || done_q.size() != 2) begin
      bad++; $display("FAIL requeue_runs: got quiet=%b starts=%0d dones=%0d want 1 2 2", ok, start_cnt, done_q.size());
    end
  endtask

  task automatic test_timeout();
    int n;
    bit ok;
    do_reset();
    clear_logs();
    resp_en = 1'b0;
    pulse_request(4'b0001);
    wait_start(10, ok);
    wait_pulse(40, n);
    total++;
    if (!ok || n != 17 || error !== 4'b0001 || done !== 4'b0000) begin
      bad++; $display("FAIL timeout_pulse: got started=%b cycles=%0d err=%b done=%b want 1 17 0001 0000", ok, n, error, done);
    end
    total++;
    if (timeout !== 1'b1) begin
      bad++; $display("FAIL timeout_flag: got %b want 1", timeout);
    end
    wait_quiet(50, ok);
    total++;
    if (timeout !== 1'b1 || done_q.size() != 0) begin
      bad++; $display("FAIL timeout_sticky: got to=%b dones=%0d want 1 0", timeout, done_q.size());
    end
    @(negedge wb_clk); stop = 1'b1;
    @(negedge wb_clk); stop = 1'b0;
    total++;
    if (timeout !== 1'b0) begin
      bad++; $display("FAIL timeout_stop_clear: got %b want 0", timeout);
    end
    resp_en = 1'b1;
  endtask

  task automatic test_stop();
    int n;
    bit ok;
    do_reset();
    clear_logs();
    resp_len = 6;
    pulse_request(4'b0111);
    wait_start(10, ok);
    total++;
    if (!ok || sm.sm_select !== 2'd0) begin
      bad++; $display("FAIL stop_first: got started=%b sel=%0d want 1 0", ok, sm.sm_select);
    end
    @(negedge wb_clk); stop = 1'b1;
    @(negedge wb_clk); stop = 1'b0;
    total++;
    if (pending !== 4'b0000) begin
      bad++; $display("FAIL stop_flush: got %b want 0000", pending);
    end
    wait_pulse(30, n);
    total++;
    if (done !== 4'b0001 || error !== 4'b0000) begin
      bad++; $display("FAIL stop_finish: got done=%b err=%b want 0001 0000", done, error);
    end
    repeat (10) @(negedge wb_clk);
    total++;
    if (start_cnt != 1 || busy !== 1'b0) begin
      bad++; $display("FAIL stop_no_relaunch: got starts=%0d busy=%b want 1 0", start_cnt, busy);
    end
  endtask

  task automatic test_bus_error();
    int n;
    bit ok;
    clear_logs();
    resp_err = 1'b1;
    resp_len = 4;
    pulse_request(4'b1000);
    wait_pulse(30, n);
    total++;
    if (error !== 4'b1000 || done !== 4'b0000) begin
      bad++; $display("FAIL bus_error: got err=%b done=%b want 1000 0000", error, done);
    end
    resp_err = 1'b0;
    wait_quiet(50, ok);
    total++;
    if (overlap_seen) begin
      bad++; $display("FAIL pulse_exclusive: got overlap=1 want 0");
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    clear_logs();
    resp_len = 8;
    pulse_request(4'b0100);
    while (state_dbg !== 3'd3 && n < 20) begin @(negedge wb_clk); n++; end
    wb_rst = 1'b1;
    @(negedge wb_clk);
    total++;
    if (state_dbg !== 3'd3 && n >= 20) begin
      bad++; $display("FAIL reset_mid_reach: got state=%0d want 3 before reset", state_dbg);
    end else if ({sm.sm_start, sm.sm_select, busy, done, error, timeout, pending, state_dbg} !== '0 ||
                 sm.sm_base_address !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid_outputs: got state=%0d busy=%b pend=%b base=%h want 0 0 0000 0",
               state_dbg, busy, pending, sm.sm_base_address);
    end
    wb_rst = 1'b0;
    repeat (12) @(negedge wb_clk);
    total++;
    if (busy !== 1'b0 || start_cnt != 1 || done_q.size() != 0 || err_q.size() != 0) begin
      bad++; $display("FAIL reset_mid_idle: got busy=%b starts=%0d dones=%0d errs=%0d want 0 1 0 0",
                      busy, start_cnt, done_q.size(), err_q.size());
    end
  endtask

  initial begin
    eq0_addr = 32'h1000_0000;
    eq1_addr = 32'h2000_0100;
    eq2_addr = 32'h3000_0200;
    eq3_addr = 32'h4000_0300;
    wb_rst = 1'b1; request = 4'b0; stop = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_requeue();
    test_timeout();
    test_stop();
    test_bus_error();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_dsp_equation_scheduler.md
Name: wb_dsp_equation_scheduler

Overview:
Round-robin scheduler that sits between the DSP slave register block and the equation state machine. It queues start requests for equations 0-3 and grants them one at a time. For each grant it launches the state machine with the matching base address and tracks the run to completion or timeout. It then reports per-equation done/error pulses and status for the status register.

Parameters:
dw, 32, data width of equation address registers
aw, 32, width of sm_base_address
TIMEOUT, 1024, max cycles per run from launch to completion; 0 disables the timeout
TW, 16, width of the timeout counter; TIMEOUT must be < 2^TW

Ports:
wb_clk  in  1  system clock, all logic on rising edge
wb_rst  in  1  synchronous active-high reset
request  in  4  per-equation start request, level-sampled each cycle (begin_equation | control_reg[3:0])
stop  in  1  control_reg stop bit: flushes queued requests
equation0_address_reg  in  dw  base address, equation 0
equation1_address_reg  in  dw  base address, equation 1
equation2_address_reg  in  dw  base address, equation 2
equation3_address_reg  in  dw  base address, equation 3
sm_active  in  1  equation state machine busy
sm_error  in  1  equation state machine bus error (wb_err seen)
sm_start  out  1  one-cycle launch pulse to equation state machine
sm_base_address  out  aw  base address of granted equation, stable from launch until next launch
sm_select  out  2  index of granted equation
pending  out  4  queued-but-not-completed requests
busy  out  1  high in any state other than IDLE
done  out  4  one-cycle pulse, bit i = equation i completed cleanly
error  out  4  one-cycle pulse, bit i = equation i ended with sm_error or timeout
timeout  out  1  sticky; set on any timeout; cleared by reset or stop

Behaviour:
- Reset: every output is 0 and state is IDLE. Internal last_grant = 3, so equation 0 wins first. The timeout counter is 0.
- pending[i] sets on the edge where request[i]=1. It clears in COMPLETE for the granted index. If set and clear hit the same bit together, set wins and the equation is re-queued.
- stop=1 clears all pending bits and timeout. Set is suppressed while stop=1. A run already in flight is not aborted; it completes normally.
- Arbitration (combinational in IDLE): pick the first set pending bit searching from last_grant+1 mod 4 upward with wrap.
- IDLE:
  - if |pending and !stop: latch grant into sm_select, latch the matching address (truncated/zero-extended to aw) into sm_base_address, go to LAUNCH.
- LAUNCH: sm_start=1 for exactly this cycle, clear the timeout counter, go to WAIT_ACTIVE.
- WAIT_ACTIVE: count cycles.
  - sm_active=1: go to WAIT_DONE.
  - counter reaches TIMEOUT-1 (TIMEOUT!=0): set timeout and the error flag, go to COMPLETE.
- WAIT_DONE: count cycles; sm_error=1 on any cycle sets the internal error flag.
  - sm_active=0: go to COMPLETE.
  - counter reaches TIMEOUT-1: set timeout and the error flag, go to COMPLETE.
- COMPLETE:
  - pulse done[sm_select] if the error flag is clear, else pulse error[sm_select].
  - clear pending[sm_select], set last_grant=sm_select, clear the error flag, go to IDLE.
- Latency: request sampled at edge N, then pending=1 after N and sm_start=1 in the cycle after edge N+1. Minimum request-to-done is 4 cycles plus the state machine's active time.
- Back-to-back: one IDLE cycle separates COMPLETE from the next LAUNCH.
- Only one sm_start per grant. done and error are never both set, and at most one bit of each is set.
- Reset mid-run returns to IDLE immediately and drops pending. sm_active is ignored in IDLE.

Test Plan:
- Single request: request=4'b0100 for one cycle, state machine active for 5 cycles → sm_start pulses once 2 cycles later, sm_select=2, sm_base_address=equation2_address_reg, then done=4'b0100 pulse and pending=0.
- Fairness: request=4'b1111 held for 1 cycle, state machine active 3 cycles per run → grants in order 0,1,2,3. Then request=4'b0011 → grants 0,1 (last_grant=3 wraps to 0).
- Re-queue: assert request[1] in the same cycle as COMPLETE for equation 1 → pending[1] stays 1 and equation 1 relaunches after one IDLE cycle.
- Timeout: TIMEOUT=16, sm_active never rises → error=4'b0001 pulse after 16 cycles in WAIT_ACTIVE, timeout=1, no done pulse; stop=1 then clears timeout.
- Stop: three requests queued, stop=1 while equation 0 runs → equation 0 finishes with done[0], pending=0, no further sm_start.
- Bus error / reset: sm_error=1 mid-run → error pulse instead of done. wb_rst asserted in WAIT_DONE → all outputs 0 next cycle and state IDLE.
